pagerank_iter_sched: RTL

//  Iteration scheduler for the serial PageRank DMP datapath. Sequences one

---
 rtl/pagerank_iter_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pagerank_iter_sched.sv
// Iteration scheduler for the serial PageRank datapath: one sweep per iteration, one request per partition.
// Tracks the max partition delta per sweep, commits the rank buffers, and stops on convergence or on the iteration cap.
module pagerank_iter_sched #(
  parameter int NUM_PARTITIONS = 1,
  parameter int MAX_ITERATIONS = 64,
  parameter int DELTA_W        = 32,
  parameter int PW             = (NUM_PARTITIONS > 1) ? $clog2(NUM_PARTITIONS) : 1,
  parameter int IW             = $clog2(MAX_ITERATIONS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [DELTA_W-1:0] threshold_i,
  output logic               part_req_valid_o,
  input  logic               part_req_ready_i,
  output logic [PW-1:0]      part_req_idx_o,
  input  logic               part_resp_valid_i,
  input  logic [DELTA_W-1:0] part_resp_delta_i,
  output logic               commit_o,
  output logic               next_iteration_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               converged_o,
  output logic               timed_out_o,
  output logic [IW-1:0]      iter_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_COMMIT, S_CHECK, S_DONE
  } state_t;

  localparam logic [PW-1:0] LAST_PTR = PW'(NUM_PARTITIONS - 1);
  localparam logic [IW-1:0] ITER_CAP = IW'(MAX_ITERATIONS);

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [DELTA_W-1:0] max_delta_q, max_delta_d;
  logic [DELTA_W-1:0] thr_q, thr_d;
  logic [IW-1:0]      iter_q, iter_d;
  logic               conv_q, conv_d;
  logic               tout_q, tout_d;
  logic               next_iter;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      max_delta_q <= '0;
      thr_q       <= '0;
      iter_q      <= '0;
      conv_q      <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      max_delta_q <= max_delta_d;
      thr_q       <= thr_d;
      iter_q      <= iter_d;
      conv_q      <= conv_d;
      tout_q      <= tout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    max_delta_d = max_delta_q;
    thr_d       = thr_q;
    iter_d      = iter_q;
    conv_d      = conv_q;
    tout_d      = tout_q;
    next_iter   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          thr_d       = threshold_i;
          iter_d      = '0;
          ptr_d       = '0;
          max_delta_d = '0;
          conv_d      = 1'b0;
          tout_d      = 1'b0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (part_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (part_resp_valid_i) begin
          if (part_resp_delta_i > max_delta_q) max_delta_d = part_resp_delta_i;
          if (ptr_q == LAST_PTR) begin
            state_d = S_COMMIT;
          end else begin
            ptr_d   = ptr_q + PW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_COMMIT: begin
        if (iter_q != ITER_CAP) iter_d = iter_q + IW'(1);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // Convergence is tested first so it wins when the cap is reached on the same sweep.
        if (max_delta_q < thr_q) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (iter_q == ITER_CAP) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          next_iter   = 1'b1;
          ptr_d       = '0;
          max_delta_d = '0;
          state_d     = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i) begin
      state_d     = S_IDLE;
      ptr_d       = '0;
      max_delta_d = '0;
      iter_d      = '0;
      conv_d      = 1'b0;
      tout_d      = 1'b0;
      next_iter   = 1'b0;
    end
  end

  assign part_req_valid_o = (state_q == S_ISSUE);
  assign part_req_idx_o   = ptr_q;
  assign commit_o         = (state_q == S_COMMIT);
  assign next_iteration_o = next_iter;
  assign busy_o           = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                            (state_q == S_COMMIT) || (state_q == S_CHECK);
  assign done_o           = (state_q == S_DONE);
  assign converged_o      = conv_q;
  assign timed_out_o      = tout_q;
  assign iter_count_o     = iter_q;

endmodule
